pe_pooling_window: RTL and testbench

Window-forming stage directly upstream of the pooling processing element. It accepts a raster-order pixel stream (one pixel of `pCHANNEL` channels per handshake) and buffers `pKERNEL_SIZE-1` image rows. At each stride-aligned position it emits one complete `pKERNEL_SIZE x pKERNEL_SIZE` receptive field on a flat bus. The emitted bus and its enable pulse drive the pooling PE's `data_in` / `en` directly.

---
 rtl/pooling_pkg.sv | 27 ++
 rtl/pe_line_buffer.sv | 34 +++
 rtl/pe_pooling_window.sv | 172 +++++++++++++++++
 tb/tb_pe_pooling_window.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pooling_pkg.sv
// Shared definitions for the pooling datapath: window indexing, the pixel
// typedef pattern and window-count arithmetic reused by the PE scoreboard.
package pooling_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_CHANNEL    = 1;

    // Pixel pattern: channel-major packed sample array. Modules redeclare it
    // with their own parameters so channel c sits at [c*DATA_WIDTH +: DATA_WIDTH].
    typedef logic [DEF_CHANNEL-1:0][DEF_DATA_WIDTH-1:0] pixel_t;

    // Flat position of window pixel (row r, column c) in a k x k window.
    function automatic int win_idx(input int r, input int c, input int k);
        return r * k + c;
    endfunction

    // Number of stride-aligned windows that fit along an axis of n pixels.
    function automatic int windows_per_axis(input int n, input int k, input int s);
        return (n - k) / s + 1;
    endfunction

    // Coordinate of the bottom/right pixel of the last window along an axis.
    function automatic int last_aligned(input int n, input int k, input int s);
        return k - 1 + (windows_per_axis(n, k, s) - 1) * s;
    endfunction

endpackage

// File: rtl/pe_line_buffer.sv
// One image-row delay: circular RAM addressed by the column counter. The
// read returns the pixel written one row earlier at the same column, and the
// new pixel overwrites it on the same accepting edge.
module pe_line_buffer
    import pooling_pkg::*;
#(
    parameter  int pWIDTH = 8,
    parameter  int pDEPTH = 32,
    localparam int AW     = (pDEPTH > 1) ? $clog2(pDEPTH) : 1
) (
    input  logic              clk,
    input  logic              en,
    input  logic [AW-1:0]     addr,
    input  logic [pWIDTH-1:0] wr_data,
    output logic [pWIDTH-1:0] rd_data
);

    logic [pWIDTH-1:0] mem [pDEPTH];

    // Read-before-write: the combinational read sees the old row's pixel.
    assign rd_data = mem[addr];

    // Row storage write on every accepted pixel.
    // NOTE: memory arrays are deliberately left out of reset; every column is
    // rewritten before a window can ever read it, and a reset here would
    // prevent RAM inference. Non-blocking assignment keeps the write ordered
    // after all same-edge reads of the cascade.
    always_ff @(posedge clk) begin
        if (en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/pe_pooling_window.sv
// Window-forming stage ahead of the pooling PE: buffers K-1 rows of a
// raster pixel stream and emits each stride-aligned K x K receptive field as
// a one-cycle strobe on a flat bus.
module pe_pooling_window
    import pooling_pkg::*;
#(
    parameter int pDATA_WIDTH  = 8,
    parameter int pCHANNEL     = 1,
    parameter int pKERNEL_SIZE = 3,
    parameter int pSTRIDE      = 3,
    parameter int pIMG_WIDTH   = 32,
    parameter int pIMG_HEIGHT  = 32
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  in_valid,
    output logic                                                  in_ready,
    input  logic [pDATA_WIDTH*pCHANNEL-1:0]                       in_data,
    input  logic                                                  out_ready,
    output logic                                                  out_valid,
    output logic [pDATA_WIDTH*pCHANNEL*pKERNEL_SIZE*pKERNEL_SIZE-1:0] out_data,
    output logic                                                  out_last
);

    localparam int K     = pKERNEL_SIZE;
    localparam int S     = pSTRIDE;
    localparam int W     = pIMG_WIDTH;
    localparam int H     = pIMG_HEIGHT;
    localparam int PIX_W = pDATA_WIDTH * pCHANNEL;
    localparam int OUT_W = PIX_W * K * K;
    localparam int CW    = (W > 1) ? $clog2(W) : 1;
    localparam int RW    = (H > 1) ? $clog2(H) : 1;
    localparam int PHW   = (S > 1) ? $clog2(S) : 1;

    localparam logic [CW-1:0]  COL_MAX  = CW'(W - 1);
    localparam logic [CW-1:0]  COL_K    = CW'(K - 1);
    localparam logic [CW-1:0]  COL_LAST = CW'(last_aligned(W, K, S));
    localparam logic [RW-1:0]  ROW_MAX  = RW'(H - 1);
    localparam logic [RW-1:0]  ROW_K    = RW'(K - 1);
    localparam logic [RW-1:0]  ROW_LAST = RW'(last_aligned(H, K, S));
    localparam logic [PHW-1:0] PH_MAX   = PHW'(S - 1);

    typedef logic [pCHANNEL-1:0][pDATA_WIDTH-1:0] pix_t;

    logic [CW-1:0]  col_q;
    logic [RW-1:0]  row_q;
    logic [PHW-1:0] col_ph_q;
    logic [PHW-1:0] row_ph_q;
    logic           accept;
    logic           emit;
    logic           is_last;
    logic           col_wrap;
    logic           row_wrap;
    pix_t           in_pix;
    pix_t           lb_in   [K-1];
    pix_t           lb_out  [K-1];
    pix_t           col_vec [K];
    pix_t           win_q   [K][K];
    pix_t           win_d   [K][K];
    logic [OUT_W-1:0] out_d;

    // The whole stage stalls with the consumer; there is no skid buffer.
    assign in_ready = out_ready & ~rst;
    assign accept   = in_valid & in_ready;
    assign in_pix   = in_data;

    assign col_wrap = (col_q == COL_MAX);
    assign row_wrap = (row_q == ROW_MAX);
    assign emit     = accept & (row_q >= ROW_K) & (col_q >= COL_K)
                      & (row_ph_q == '0) & (col_ph_q == '0);
    assign is_last  = (row_q == ROW_LAST) & (col_q == COL_LAST);

    // Raster position and stride phase of the pixel being accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q    <= '0;
            row_q    <= '0;
            col_ph_q <= '0;
            row_ph_q <= '0;
        end else if (accept) begin
            if (col_wrap) begin
                col_q    <= '0;
                col_ph_q <= '0;
                if (row_wrap) begin
                    row_q    <= '0;
                    row_ph_q <= '0;
                end else begin
                    row_q <= row_q + 1'b1;
                    if (row_q >= ROW_K) begin
                        row_ph_q <= (row_ph_q == PH_MAX) ? '0 : row_ph_q + 1'b1;
                    end
                end
            end else begin
                col_q <= col_q + 1'b1;
                if (col_q >= COL_K) begin
                    col_ph_q <= (col_ph_q == PH_MAX) ? '0 : col_ph_q + 1'b1;
                end
            end
        end
    end

    // Cascaded row delays: buffer j outputs the pixel from row-(j+1).
    for (genvar j = 0; j < K - 1; j++) begin : g_lb
        if (j == 0) begin : g_head
            assign lb_in[j] = in_pix;
        end else begin : g_chain
            assign lb_in[j] = lb_out[j-1];
        end

        pe_line_buffer #(
            .pWIDTH (PIX_W),
            .pDEPTH (W)
        ) u_line_buffer (
            .clk     (clk),
            .en      (accept),
            .addr    (col_q),
            .wr_data (lb_in[j]),
            .rd_data (lb_out[j])
        );
    end

    // Column vector, top (oldest row) first; the live pixel is the bottom entry.
    for (genvar r = 0; r < K - 1; r++) begin : g_col_vec
        assign col_vec[r] = lb_out[K-2-r];
    end
    assign col_vec[K-1] = in_pix;

    // Next window: shift left one column and append the column vector.
    for (genvar r = 0; r < K; r++) begin : g_win_row
        for (genvar c = 0; c < K - 1; c++) begin : g_win_shift
            assign win_d[r][c] = win_q[r][c+1];
        end
        assign win_d[r][K-1] = col_vec[r];

        for (genvar c = 0; c < K; c++) begin : g_pack
            assign out_d[win_idx(r, c, K)*PIX_W +: PIX_W] = win_d[r][c];
        end
    end

    // Window register advances on every accepted pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else if (accept) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    win_q[r][c] <= win_d[r][c];
                end
            end
        end
    end

    // Output strobe one cycle after the bottom-right pixel; data holds between windows.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= emit;
            out_last  <= emit & is_last;
            if (emit) begin
                out_data <= out_d;
            end
        end
    end

endmodule

// File: tb/tb_pe_pooling_window.sv
// Self-checking bench for pe_pooling_window: three parameterisations share
// one stimulus stream; a raster-image model predicts every output cycle of
// the selected instance, and literal windows pin the model itself.
module tb_pe_pooling_window;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic [15:0]  in_data;

    logic         a_in_ready, a_out_valid, a_out_last;
    logic [71:0]  a_out_data;
    logic         b_in_ready, b_out_valid, b_out_last;
    logic [71:0]  b_out_data;
    logic         c_in_ready, c_out_valid, c_out_last;
    logic [143:0] c_out_data;

    always #5 clk = ~clk;

    // 6x6, K=3, S=3, one channel
    pe_pooling_window #(
        .pDATA_WIDTH(8), .pCHANNEL(1), .pKERNEL_SIZE(3), .pSTRIDE(3),
        .pIMG_WIDTH(6), .pIMG_HEIGHT(6)
    ) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data[7:0]), .out_ready(out_ready), .out_valid(a_out_valid),
        .out_data(a_out_data), .out_last(a_out_last)
    );

    // 5x5, K=3, S=1, one channel
    pe_pooling_window #(
        .pDATA_WIDTH(8), .pCHANNEL(1), .pKERNEL_SIZE(3), .pSTRIDE(1),
        .pIMG_WIDTH(5), .pIMG_HEIGHT(5)
    ) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data[7:0]), .out_ready(out_ready), .out_valid(b_out_valid),
        .out_data(b_out_data), .out_last(b_out_last)
    );

    // 6x6, K=3, S=3, two channels
    pe_pooling_window #(
        .pDATA_WIDTH(8), .pCHANNEL(2), .pKERNEL_SIZE(3), .pSTRIDE(3),
        .pIMG_WIDTH(6), .pIMG_HEIGHT(6)
    ) u_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_data(in_data), .out_ready(out_ready), .out_valid(c_out_valid),
        .out_data(c_out_data), .out_last(c_out_last)
    );

    int sel;
    int cfg_w [3] = '{6, 5, 6};
    int cfg_s [3] = '{3, 1, 3};
    int cfg_c [3] = '{1, 1, 2};

    logic         d_in_ready, d_valid, d_last;
    logic [143:0] d_data;

    always_comb begin
        d_in_ready = c_in_ready;
        d_valid    = c_out_valid;
        d_last     = c_out_last;
        d_data     = c_out_data;
        if (sel == 0) begin
            d_in_ready = a_in_ready;
            d_valid    = a_out_valid;
            d_last     = a_out_last;
            d_data     = {72'b0, a_out_data};
        end else if (sel == 1) begin
            d_in_ready = b_in_ready;
            d_valid    = b_out_valid;
            d_last     = b_out_last;
            d_data     = {72'b0, b_out_data};
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Behavioural model: the frame as a 2-D image, windows cut from it.
    logic [15:0]  img [6][6];
    int           m_row, m_col;
    bit           armed = 1'b0;
    logic         exp_valid, exp_last;
    logic [143:0] exp_data;

    task automatic model_step();
        int  k, s, w, h, c, lr, lc;
        bit  emit;
        k = 3; s = cfg_s[sel]; w = cfg_w[sel]; h = w; c = cfg_c[sel];
        if (rst) begin
            m_row = 0; m_col = 0;
            exp_valid = 1'b0; exp_last = 1'b0; exp_data = '0;
            armed = 1'b1;
        end else if (in_valid && out_ready) begin
            img[m_row][m_col] = in_data;
            emit = (m_row >= k-1) && (m_col >= k-1)
                   && ((m_row-k+1) % s == 0) && ((m_col-k+1) % s == 0);
            lr = k-1 + ((h-k)/s)*s;
            lc = k-1 + ((w-k)/s)*s;
            exp_valid = emit;
            exp_last  = emit && (m_row == lr) && (m_col == lc);
            if (emit) begin
                exp_data = '0;
                for (int r = 0; r < k; r++)
                    for (int cc = 0; cc < k; cc++)
                        for (int ch = 0; ch < c; ch++)
                            exp_data[((r*k+cc)*c+ch)*8 +: 8] = img[m_row-k+1+r][m_col-k+1+cc][ch*8 +: 8];
            end
            if (m_col == w-1) begin
                m_col = 0;
                m_row = (m_row == h-1) ? 0 : m_row + 1;
            end else begin
                m_col++;
            end
        end else begin
            exp_valid = 1'b0;
            exp_last  = 1'b0;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Captured DUT windows for the literal checks of each test.
    logic [143:0] win_q [$];
    bit           last_q [$];
    int           run, max_run;

    task automatic compare_step();
        if (!armed) return;
        check("in_ready", d_in_ready, out_ready & ~rst);
        check("out_valid", d_valid, exp_valid);
        check("out_data", d_data, exp_data);
        if (exp_valid) check("out_last", d_last, exp_last);
        if (d_valid) begin
            win_q.push_back(d_data);
            last_q.push_back(d_last);
            run++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
    endtask

    initial forever begin
        @(negedge clk);
        compare_step();
    end

    function automatic logic [143:0] win_at(input int i);
        if (i < win_q.size()) return win_q[i];
        return 'x;
    endfunction

    function automatic logic last_at(input int i);
        if (i < last_q.size()) return last_q[i];
        return 1'bx;
    endfunction

    function automatic logic [143:0] mk_win(input int v [9], input int chans);
        logic [143:0] b;
        b = '0;
        for (int p = 0; p < 9; p++) begin
            b[p*8*chans +: 8] = v[p][7:0];
            if (chans == 2) b[p*16+8 +: 8] = v[p][7:0] ^ 8'hFF;
        end
        return b;
    endfunction

    task automatic do_reset(input int new_sel, input int cycles);
        armed    = 1'b0;
        sel      = new_sel;
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
        win_q.delete();
        last_q.delete();
        run = 0;
        max_run = 0;
    endtask

    // mode 0: continuous, 1: out_ready low every 3rd cycle, 2: random stalls.
    task automatic drive(input int n, input int offset, input int mode, input bit rnd);
        int       i, cyc;
        bit       acc;
        logic [7:0] v;
        i = 0; cyc = 0;
        v = rnd ? 8'($urandom_range(0, 255)) : 8'(offset);
        while (i < n) begin
            in_data   = {v ^ 8'hFF, v};
            in_valid  = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            out_ready = (mode == 1) ? (cyc % 3 != 2)
                      : (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(posedge clk);
            acc = in_valid && out_ready;
            #1;
            cyc++;
            if (acc) begin
                i++;
                v = rnd ? 8'($urandom_range(0, 255)) : 8'(offset + i);
            end
            if (cyc > 50*n + 100) begin
                n_checks++;
                $display("FAIL drive_timeout: accepted %0d of %0d pixels", i, n);
                break;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic idle(input int n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    int lit_first  [9] = '{0, 1, 2, 6, 7, 8, 12, 13, 14};
    int lit_second [9] = '{3, 4, 5, 9, 10, 11, 15, 16, 17};
    int lit_s1_last[9] = '{12, 13, 14, 17, 18, 19, 22, 23, 24};
    int lit_off    [9] = '{100, 101, 102, 106, 107, 108, 112, 113, 114};

    logic [143:0] ref_q [$];
    logic [143:0] tmp;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_data = '0; sel = 0;

        // Reset state
        do_reset(0, 2);
        check("reset_out_valid", d_valid, 1'b0);
        check("reset_out_last", d_last, 1'b0);
        check("reset_out_data", d_data, '0);

        // Test 1: 6x6, K=S=3, continuous
        drive(36, 0, 0, 1'b0);
        idle(4);
        check("t1_count", win_q.size(), 4);
        check("t1_win0", win_at(0), mk_win(lit_first, 1));
        check("t1_win1", win_at(1), mk_win(lit_second, 1));
        tmp = win_at(3);
        check("t1_win3_p8", tmp[64 +: 8], 8'd35);
        check("t1_win0_last", last_at(0), 1'b0);
        check("t1_win3_last", last_at(3), 1'b1);
        ref_q = win_q;

        // Test 2: same frame with out_ready low every 3rd cycle
        do_reset(0, 2);
        drive(36, 0, 1, 1'b0);
        idle(4);
        check("t2_count", win_q.size(), 4);
        for (int i = 0; i < 4; i++) check($sformatf("t2_win%0d", i), win_at(i), ref_q[i]);

        // Test 3: 5x5, K=3, S=1
        do_reset(1, 2);
        drive(25, 0, 0, 1'b0);
        idle(4);
        check("t3_count", win_q.size(), 9);
        check("t3_max_run", max_run, 3);
        check("t3_win8", win_at(8), mk_win(lit_s1_last, 1));
        check("t3_win8_last", last_at(8), 1'b1);

        // Test 4: back-to-back frames, offsets 0 and 100
        do_reset(0, 2);
        drive(36, 0, 0, 1'b0);
        drive(36, 100, 0, 1'b0);
        idle(4);
        check("t4_count", win_q.size(), 8);
        check("t4_win4", win_at(4), mk_win(lit_off, 1));
        check("t4_win3_last", last_at(3), 1'b1);
        check("t4_win7_last", last_at(7), 1'b1);

        // Test 5: reset after 20 pixels, then a full frame
        do_reset(0, 2);
        drive(20, 0, 0, 1'b0);
        in_valid = 1'b1;
        do_reset(0, 1);
        drive(36, 0, 0, 1'b0);
        idle(4);
        check("t5_count", win_q.size(), 4);
        for (int i = 0; i < 4; i++) check($sformatf("t5_win%0d", i), win_at(i), ref_q[i]);

        // Test 6: two channels, channel 1 = channel 0 ^ 0xFF
        do_reset(2, 2);
        drive(36, 0, 0, 1'b0);
        idle(4);
        check("t6_count", win_q.size(), 4);
        tmp = win_at(0);
        for (int p = 0; p < 9; p++) begin
            check($sformatf("t6_p%0d_ch0", p), tmp[p*16 +: 8], 8'(lit_first[p]));
            check($sformatf("t6_p%0d_ch1", p), tmp[p*16+8 +: 8], 8'(lit_first[p]) ^ 8'hFF);
        end

        // Test 7: random data with random valid/ready stalls, two frames each
        for (int s = 0; s < 3; s++) begin
            do_reset(s, 2);
            drive(2*cfg_w[s]*cfg_w[s], 0, 2, 1'b1);
            idle(4);
            check($sformatf("t7_sel%0d_count", s), win_q.size(), (s == 1) ? 18 : 8);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at 2000000 ns, limit 2000000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
